// File: rtl/plusarg_writer.sv
// Buffers a valid/ready word stream in a FIFO and drains it at a fixed pace, printing each word in simulation.
// Optional build macro PLUSARG_WRITER_FINISH_EN: report the exit code and call $finish once done rises.
module plusarg_writer #(
    parameter string FORMAT    = "value=%d",
    parameter int    WIDTH     = 32,
    parameter int    DEPTH     = 4,
    parameter int    DRAIN_GAP = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_exit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     written,
    output logic                     done,
    output logic [WIDTH-1:0]         exit_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef PLUSARG_WRITER_FINISH_EN
    localparam bit FINISH_EN = 1'b1;
`else
    localparam bit FINISH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GAP, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        gap_cnt, gap_nxt;
    logic [WIDTH-1:0]  mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_exit;
    logic [AW-1:0]     wptr, rptr;
    logic              exit_seen;
    logic              push, pop;
    logic [WIDTH-1:0]  head_data;
    logic              head_exit;

    // Space is judged on the registered count only, so a same-edge pop never makes room.
    assign in_ready  = (count != CW'(DEPTH)) && !exit_seen;
    assign push      = in_valid && in_ready;
    assign head_data = mem_data[rptr];
    assign head_exit = mem_exit[rptr];

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_exit) begin
                        state_nxt = DONE;
                    end else if (DRAIN_GAP != 0) begin
                        state_nxt = GAP;
                        gap_nxt   = 8'(DRAIN_GAP - 1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_nxt = IDLE;
                else                 gap_nxt   = gap_cnt - 8'd1;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gap_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            exit_seen <= 1'b0;
            written   <= 1'b0;
            done      <= 1'b0;
            exit_code <= '0;
        end else begin
            written <= pop;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (push && in_exit) exit_seen <= 1'b1;
            if (pop && head_exit) begin
                done      <= 1'b1;
                exit_code <= head_data;
            end
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wptr] <= in_data;
            mem_exit[wptr] <= in_exit;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (pop) $display(FORMAT, head_data);
    end
`endif

    if (FINISH_EN) begin : g_finish
        logic done_d;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) done_d <= 1'b0;
            else          done_d <= done;
        end

`ifndef SYNTHESIS
        always_ff @(posedge clock) begin
            if (reset_n && done && !done_d) begin
                if (exit_code != '0) $display("*** FAILED *** exit_code=%0d", exit_code);
                else                 $display("exit_code=%0d", exit_code);
                $finish;
            end
        end
`endif
    end

endmodule
